dm_load_unit: RTL and testbench

//  Read-side companion of the byte-enable data memory. Accepts load requests from the MEM stage and

---
 rtl/mips_mem_pkg.sv | 32 +++
 rtl/dm_load_unit_if.sv | 39 +++
 rtl/dm_load_unit_load_extend.sv | 63 ++++++
 rtl/dm_load_unit.sv | 95 +++++++++
 tb/tb_dm_load_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared memory-side definitions for the MIPS data path.
// Load type codes, exception flag value and store byte-lane encodings.
package mips_mem_pkg;

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LHU = 3'b010;
   localparam logic [2:0] LD_LB  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LWL = 3'b101;
   localparam logic [2:0] LD_LWR = 3'b110;
   localparam logic [2:0] LD_RSV = 3'b111;

   localparam logic EXC_ADEL = 1'b1;

   localparam logic [3:0] BWE_NONE = 4'b0000;
   localparam logic [3:0] BWE_B0   = 4'b0001;
   localparam logic [3:0] BWE_B1   = 4'b0010;
   localparam logic [3:0] BWE_B2   = 4'b0100;
   localparam logic [3:0] BWE_B3   = 4'b1000;
   localparam logic [3:0] BWE_H0   = 4'b0011;
   localparam logic [3:0] BWE_H1   = 4'b1100;
   localparam logic [3:0] BWE_W    = 4'b1111;

   typedef struct packed {
      logic [1:0]  b;
      logic [2:0]  ld_type;
      logic [31:0] rt;
      logic        exc;
   } s1_t;

endpackage

// File: rtl/dm_load_unit_if.sv
// Request, DM read port and response bundle of the load unit.
// slave = the load unit, master = MEM/WB/DM side.
interface dm_load_unit_if #(
   parameter int AW = 13,
   parameter int DW = 32
);

   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [2:0]    req_type;
   logic [DW-1:0] req_rt;
   logic          mem_re;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_data;
   logic          resp_exc;

   modport slave (
      input  req_valid, req_addr, req_type, req_rt,
      output req_ready,
      output mem_re, mem_addr,
      input  mem_rdata,
      output resp_valid, resp_data, resp_exc,
      input  resp_ready
   );

   modport master (
      output req_valid, req_addr, req_type, req_rt,
      input  req_ready,
      input  mem_re, mem_addr,
      output mem_rdata,
      input  resp_valid, resp_data, resp_exc,
      output resp_ready
   );

endinterface

// File: rtl/dm_load_unit_load_extend.sv
// Combinational load extraction: byte/half select, extension,
// LWL/LWR merge with rt, and address-error detection.
module load_extend
   import mips_mem_pkg::*;
(
   input  logic [31:0] w,
   input  logic [1:0]  b,
   input  logic [2:0]  ld_type,
   input  logic [31:0] rt,
   output logic [31:0] data,
   output logic        exc_chk
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        mis;

   assign byte_v = 8'(w >> {b, 3'b000});
   assign half_v = b[1] ? w[31:16] : w[15:0];

   // Decode the load type into the result word and a misalignment flag.
   always_comb begin
      mis  = 1'b0;
      data = '0;
      unique case (ld_type)
         LD_LW: begin
            mis  = |b;
            data = w;
         end
         LD_LH: begin
            mis  = b[0];
            data = {{16{half_v[15]}}, half_v};
         end
         LD_LHU: begin
            mis  = b[0];
            data = {16'h0, half_v};
         end
         LD_LB:  data = {{24{byte_v[7]}}, byte_v};
         LD_LBU: data = {24'h0, byte_v};
         LD_LWL: begin
            unique case (b)
               2'd0: data = {w[7:0],  rt[23:0]};
               2'd1: data = {w[15:0], rt[15:0]};
               2'd2: data = {w[23:0], rt[7:0]};
               2'd3: data = w;
            endcase
         end
         LD_LWR: begin
            unique case (b)
               2'd0: data = w;
               2'd1: data = {rt[31:24], w[31:8]};
               2'd2: data = {rt[31:16], w[31:16]};
               2'd3: data = {rt[31:8],  w[31:24]};
            endcase
         end
         default: mis = 1'b1;
      endcase
      if (mis) data = '0;
   end

   assign exc_chk = mis ? EXC_ADEL : 1'b0;

endmodule

// File: rtl/dm_load_unit.sv
// Two-stage load unit: S1 waits for the DM word (with a hold
// register for stalls), S2 is the registered response to WB.
module dm_load_unit
   import mips_mem_pkg::*;
(
   input logic     clk,
   input logic     reset_n,
   dm_load_unit_if.slave bus
);

   logic        s1_valid;
   logic        s1_fresh;
   s1_t         s1_q;
   logic [31:0] s1_data;
   logic [31:0] s1_word;
   logic [31:0] s1_res;
   logic        s1_adv;
   logic        accept;
   logic        exc_now;
   logic [31:0] req_ext_unused;
   logic        s1_chk_unused;

   assign s1_adv        = s1_valid && (!bus.resp_valid || bus.resp_ready);
   assign bus.req_ready = !s1_valid || s1_adv;
   assign accept        = bus.req_valid && bus.req_ready;
   assign bus.mem_re    = accept && !exc_now;
   assign bus.mem_addr  = bus.req_addr;

   // Error check at the request side, so a bad load never reads DM.
   load_extend u_req_chk (
      .w       (32'h0),
      .b       (bus.req_addr[1:0]),
      .ld_type (bus.req_type),
      .rt      (bus.req_rt),
      .data    (req_ext_unused),
      .exc_chk (exc_now)
   );

   // Live DM word on the first S1 cycle, captured copy afterwards.
   assign s1_word = s1_fresh ? bus.mem_rdata : s1_data;

   load_extend u_s1_ext (
      .w       (s1_word),
      .b       (s1_q.b),
      .ld_type (s1_q.ld_type),
      .rt      (s1_q.rt),
      .data    (s1_res),
      .exc_chk (s1_chk_unused)
   );

   // S1 entry: register request attributes on acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_fresh <= 1'b0;
         s1_q     <= '0;
      end else begin
         s1_fresh <= accept;
         if (accept) begin
            s1_valid     <= 1'b1;
            s1_q.b       <= bus.req_addr[1:0];
            s1_q.ld_type <= bus.req_type;
            s1_q.rt      <= bus.req_rt;
            s1_q.exc     <= exc_now;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Hold register: keep the DM word once the read port moves on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_data <= '0;
      end else if (s1_fresh) begin
         s1_data <= bus.mem_rdata;
      end
   end

   // S2 output register toward WB.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.resp_valid <= 1'b0;
         bus.resp_data  <= '0;
         bus.resp_exc   <= 1'b0;
      end else if (s1_adv) begin
         bus.resp_valid <= 1'b1;
         bus.resp_data  <= s1_res;
         bus.resp_exc   <= s1_q.exc;
      end else if (bus.resp_ready) begin
         bus.resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dm_load_unit.sv
// Randomized scoreboard bench for dm_load_unit with a
// behavioural load model and a registered DM model.
module tb_dm_load_unit;
   import mips_mem_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   dm_load_unit_if #(.AW(13), .DW(32)) bus ();

   dm_load_unit u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic        exc;
      logic [31:0] data;
      int          acc_cyc;
   } exp_t;

   logic [31:0] dm [0:2047];
   exp_t        sb [$];
   int          rcyc [$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          lat_mode = 0;
   bit          done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // DM model: registered read, garbage when not reading.
   always @(posedge clk)
      bus.mem_rdata <= bus.mem_re ? dm[bus.mem_addr[12:2]] : $urandom;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h at cycle %0d",
                  name, act, expv, cyc);
      end
   endtask

   function automatic logic [32:0] model(input logic [31:0] w,
                                         input logic [12:0] a,
                                         input logic [2:0]  t,
                                         input logic [31:0] rt);
      int b;
      logic [31:0] v;
      logic [31:0] m;
      logic bad;
      b = int'(a[1:0]);
      v = 32'h0;
      bad = 1'b0;
      case (t)
         3'd0: begin
            bad = (b != 0);
            v = w;
         end
         3'd1, 3'd2: begin
            bad = (b % 2) != 0;
            v = (w >> (16 * (b / 2))) & 32'hFFFF;
            if (t == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         3'd3, 3'd4: begin
            v = (w >> (8 * b)) & 32'hFF;
            if (t == 3'd3 && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         3'd5: begin
            m = (b == 3) ? 32'h0 : (32'hFFFF_FFFF >> (8 * (b + 1)));
            v = (w << (8 * (3 - b))) | (rt & m);
         end
         3'd6: begin
            m = (b == 0) ? 32'h0 : ~(32'hFFFF_FFFF >> (8 * b));
            v = (w >> (8 * b)) | (rt & m);
         end
         default: bad = 1'b1;
      endcase
      if (bad) v = 32'h0;
      return {bad, v};
   endfunction

   // Monitor: push on request handshake, pop and compare on response.
   logic [32:0] mon_e;
   exp_t        mon_x;
   exp_t        mon_p;
   bit          hold_v = 0;
   logic [31:0] hold_d;
   logic        hold_e;
   always @(negedge clk) begin
      if (!reset_n) begin
         hold_v = 0;
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            mon_e = model(dm[bus.req_addr[12:2]], bus.req_addr,
                          bus.req_type, bus.req_rt);
            mon_p.exc = mon_e[32];
            mon_p.data = mon_e[31:0];
            mon_p.acc_cyc = cyc;
            sb.push_back(mon_p);
            chk("mem_re", 32'(bus.mem_re), 32'(!mon_e[32]));
            chk("mem_addr", 32'(bus.mem_addr), 32'(bus.req_addr));
         end
         if (hold_v) begin
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_data", bus.resp_data, hold_d);
            chk("hold_exc", 32'(bus.resp_exc), 32'(hold_e));
         end
         if (bus.resp_valid && bus.resp_ready) begin
            rcyc.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp: got data %h with no request outstanding",
                        bus.resp_data);
            end else begin
               mon_x = sb.pop_front();
               chk("resp_data", bus.resp_data, mon_x.data);
               chk("resp_exc", 32'(bus.resp_exc), 32'(mon_x.exc));
               if (lat_mode) chk("latency", cyc - mon_x.acc_cyc, 32'd2);
            end
         end
         hold_v = bus.resp_valid && !bus.resp_ready;
         hold_d = bus.resp_data;
         hold_e = bus.resp_exc;
      end
   end

   task automatic issue(input logic [12:0] a, input logic [2:0] t,
                        input logic [31:0] rt);
      bit acc;
      acc = 0;
      bus.req_valid = 1'b1;
      bus.req_addr = a;
      bus.req_type = t;
      bus.req_rt = rt;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = bus.req_ready;
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      if (!acc) chk("issue_accept", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         ok = (sb.size() == 0) && !bus.resp_valid;
      end
      @(posedge clk);
      #1;
      if (!ok) chk("drain_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      bit a;
      int n_acc;
      bus.req_valid = 1'b0;
      bus.req_addr = '0;
      bus.req_type = LD_LW;
      bus.req_rt = '0;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 2048; i++) dm[i] = $urandom;
      dm[0] = 32'h80FF_1234;
      dm[1] = 32'hAABB_CCDD;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_data", bus.resp_data, 32'd0);
      chk("rst_resp_exc", 32'(bus.resp_exc), 32'd0);
      reset_n = 1'b1;
      idle(2);

      lat_mode = 1;
      issue(13'h0003, LD_LB, 32'h0);
      idle(3);
      issue(13'h0002, LD_LHU, 32'h0);
      idle(3);
      issue(13'h0001, LD_LH, 32'h0);
      idle(3);
      issue(13'h0005, LD_LWL, 32'h1122_3344);
      issue(13'h0006, LD_LWR, 32'h1122_3344);
      issue(13'h0007, LD_RSV, 32'h0);
      drain();

      rcyc.delete();
      for (int i = 0; i < 4; i++) issue(13'(16 + 4 * i), LD_LW, 32'h0);
      drain();
      chk("b2b_count", rcyc.size(), 32'd4);
      if (rcyc.size() == 4) chk("b2b_span", rcyc[3] - rcyc[0], 32'd3);
      lat_mode = 0;

      bus.resp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr = 13'h0100;
      bus.req_type = LD_LW;
      n_acc = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a = bus.req_ready;
         @(posedge clk);
         #1;
         if (a) begin
            n_acc++;
            bus.req_addr = bus.req_addr + 13'd4;
         end
      end
      chk("bp_accepts", n_acc, 32'd2);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid = 1'b0;
      idle(2);
      bus.resp_ready = 1'b1;
      drain();

      issue(13'h0200, LD_LW, 32'h0);
      #3;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_mem_re", 32'(bus.mem_re), 32'd0);
      chk("mid_rst_resp_data", bus.resp_data, 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      fork
         begin
            for (int i = 0; i < 400; i++) begin
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
               issue(13'($urandom_range(0, 8191)),
                     3'($urandom_range(0, 7)), $urandom);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               bus.resp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.resp_ready = 1'b1;
      drain();
      chk("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
